// File: rtl/periph_bus_master.sv
// Initiator for the single-cycle peripheral register bus: turns host valid/ready
// commands into one strobed access at a time and returns data or a read timeout.
module periph_bus_master #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_read_valid,
  input  logic                  bus_irq,
  output logic                  irq_pending,
  input  logic                  irq_clear
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    err_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    irq_prev;
  logic                    accept;
  logic                    timed_out;

  assign accept    = cmd_valid && cmd_ready;
  assign timed_out = (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = cmd_write ? S_WRITE : S_READ;
      S_WRITE: state_nxt = S_RESP;
      S_READ:  state_nxt = bus_read_valid ? S_RESP : S_WAIT;
      S_WAIT:  if (bus_read_valid || timed_out) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // cmd_ready is gated by reset so the host sees no acceptance while reset is held.
  always_comb begin
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    rsp_error   = 1'b0;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    bus_address = '0;
    bus_wdata   = '0;
    case (state)
      S_IDLE:  cmd_ready = reset;
      S_WRITE: begin
        bus_write   = 1'b1;
        bus_address = addr_q;
        bus_wdata   = wdata_q;
      end
      S_READ: begin
        bus_read    = 1'b1;
        bus_address = addr_q;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = rdata_q;
        rsp_error = err_q;
      end
      default: ;
    endcase
  end

  // Counter saturates at TIMEOUT; the timeout branch leaves the state on that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cnt   <= '0;
          err_q <= 1'b0;
        end
        S_READ: if (!bus_read_valid) cnt <= CNT_W'(1);
        S_WAIT: if (!bus_read_valid) begin
          if (timed_out) err_q <= 1'b1;
          else           cnt   <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // rdata_q starts at zero so writes and timed-out reads report zero data.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && accept) begin
      addr_q  <= cmd_address;
      wdata_q <= cmd_data;
      rdata_q <= '0;
    end else if ((state == S_READ || state == S_WAIT) && bus_read_valid) begin
      rdata_q <= bus_rdata;
    end
  end

  // A rising edge beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_prev    <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_prev <= bus_irq;
      if (bus_irq && !irq_prev) irq_pending <= 1'b1;
      else if (irq_clear)       irq_pending <= 1'b0;
    end
  end

endmodule
